gpu_ddr_mem_responder: RTL

- Responder (slave) end of the GPU DDR bus driven by the PSX DDR bridge (o_targetAddr/o_burstLength/o_writeEnableMem/...).
- Backs the 1 MB GPU VRAM with on-chip byte-enabled RAM. Used for FPGA builds without external DDR and as the memory model in GPU-level benches.
- Accepts burst reads and writes, returns read bursts with fixed latency, and can inject wait-request stalls to stress the bridge.

---
 rtl/gpu_ddr_pkg.sv | 23 ++
 rtl/gpu_ddr_bram_be.sv | 32 +++
 rtl/gpu_ddr_mem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gpu_ddr_pkg.sv
// Shared types and constants for the GPU DDR responder and its byte-enabled RAM.
package gpu_ddr_pkg;
  localparam int DDR_ADDR_W = 17;
  localparam int DDR_DATA_W = 64;
  localparam int DDR_BE_W   = 8;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, WRBURST, RDBURST} ddr_state_e;

  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [DDR_ADDR_W-1:0] addr;
    logic [DDR_DATA_W-1:0] wdata;
    logic [DDR_BE_W-1:0]   be;
  } ram_req_t;

  function automatic logic [3:0] burst_beats(input logic [2:0] len);
    return (len == 3'd0) ? 4'd8 : {1'b0, len};
  endfunction
endpackage

// File: rtl/gpu_ddr_bram_be.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read port.
module gpu_ddr_bram_be
  import gpu_ddr_pkg::*;
#(
  parameter int DEPTH = 131072
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ram_req_t              req,
  output logic [DDR_DATA_W-1:0] q
);
  localparam int AW = $clog2(DEPTH);

  logic [DDR_BE_W-1:0][7:0] mem [DEPTH];
  logic [AW-1:0]            addr;

  assign addr = req.addr[AW-1:0];

  // Contents are never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (req.we) begin
      for (int b = 0; b < DDR_BE_W; b++)
        if (req.be[b]) mem[addr][b] <= req.wdata[8*b +: 8];
    end
  end

  // q only moves on a read so it holds between bursts.
  always_ff @(posedge clk) begin
    if (rst)         q <= '0;
    else if (req.re) q <= mem[addr];
  end
endmodule

// File: rtl/gpu_ddr_mem_responder.sv
// Responder end of the GPU DDR bus: burst reads/writes into on-chip VRAM,
// fixed-latency read return, optional LFSR-driven wait-request stalls.
module gpu_ddr_mem_responder
  import gpu_ddr_pkg::*;
#(
  parameter int          ADDR_W       = 17,
  parameter int          MEM_WORDS    = 131072,
  parameter int          READ_LATENCY = 2,
  parameter int          STALL_EN     = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [ADDR_W-1:0]     i_targetAddr,
  input  logic [2:0]            i_burstLength,
  output logic                  o_busyMem,
  input  logic                  i_writeEnableMem,
  input  logic                  i_readEnableMem,
  input  logic [DDR_DATA_W-1:0] i_dataMem,
  input  logic [DDR_BE_W-1:0]   i_byteEnableMem,
  output logic                  o_dataValidMem,
  output logic [DDR_DATA_W-1:0] o_dataMem,
  output logic                  o_protoErr
);
  localparam int AW     = $clog2(MEM_WORDS);
  localparam int STAGES = READ_LATENCY - 1;

  ddr_state_e            state, state_nx;
  logic [AW-1:0]         addr_q;
  logic [3:0]            cnt_q;
  logic [15:0]           lfsr;
  logic                  stall, wr_acc, rd_acc, rd_issue, rd_last, burst_done;
  logic [3:0]            beats;
  ram_req_t              req;
  logic [DDR_DATA_W-1:0] ram_q;
  logic [STAGES:0]       vld_pipe, lst_pipe;

  assign stall      = (STALL_EN != 0) && (lfsr[1:0] == 2'b00);
  assign beats      = burst_beats(i_burstLength);
  assign burst_done = vld_pipe[STAGES] && lst_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wr_acc)      state_nx = (beats == 4'd1) ? IDLE : WRBURST;
               else if (rd_acc) state_nx = RDBURST;
      WRBURST: if (wr_acc && cnt_q == 4'd1) state_nx = IDLE;
      RDBURST: if (burst_done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Beat 0 of a command goes to the RAM straight from the bus so the first
  // read word is registered on the accept edge.
  always_comb begin
    o_busyMem = stall;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    rd_issue  = 1'b0;
    rd_last   = 1'b0;
    req       = '0;
    req.wdata = i_dataMem;
    req.be    = i_byteEnableMem;
    case (state)
      IDLE: begin
        wr_acc   = i_writeEnableMem && !stall && !i_rst;
        rd_acc   = i_readEnableMem && !i_writeEnableMem && !stall && !i_rst;
        req.addr = DDR_ADDR_W'(i_targetAddr[AW-1:0]);
        req.we   = wr_acc;
        req.re   = rd_acc;
        rd_issue = rd_acc;
        rd_last  = (beats == 4'd1);
      end
      WRBURST: begin
        wr_acc   = i_writeEnableMem && !stall && !i_rst;
        req.addr = DDR_ADDR_W'(addr_q);
        req.we   = wr_acc;
      end
      RDBURST: begin
        o_busyMem = 1'b1;
        rd_issue  = (cnt_q != 4'd0) && !i_rst;
        req.addr  = DDR_ADDR_W'(addr_q);
        req.re    = rd_issue;
        rd_last   = (cnt_q == 4'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      o_protoErr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_acc || rd_acc) begin
            addr_q <= i_targetAddr[AW-1:0] + AW'(1);
            cnt_q  <= beats - 4'd1;
          end
          if (wr_acc && i_readEnableMem) o_protoErr <= 1'b1;
        end
        WRBURST: begin
          if (wr_acc) begin
            addr_q <= addr_q + AW'(1);
            cnt_q  <= cnt_q - 4'd1;
          end
          if (i_readEnableMem) o_protoErr <= 1'b1;
        end
        RDBURST: begin
          if (cnt_q != 4'd0) begin
            addr_q <= addr_q + AW'(1);
            cnt_q  <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & LFSR_TAPS);
  end

  gpu_ddr_bram_be #(.DEPTH(MEM_WORDS)) u_ram (
    .clk (clk),
    .rst (i_rst),
    .req (req),
    .q   (ram_q)
  );

  // Stage 0 lines up with the RAM output register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      lst_pipe[0] <= rd_last;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
    end
  end

  assign o_dataValidMem = vld_pipe[STAGES];

  generate
    if (STAGES == 0) begin : g_no_dly
      assign o_dataMem = ram_q;
    end else begin : g_dly
      logic [STAGES-1:0][DDR_DATA_W-1:0] dat_pipe;
      always_ff @(posedge clk) begin
        if (i_rst) dat_pipe <= '0;
        else begin
          if (vld_pipe[0]) dat_pipe[0] <= ram_q;
          for (int i = 1; i < STAGES; i++)
            if (vld_pipe[i]) dat_pipe[i] <= dat_pipe[i-1];
        end
      end
      assign o_dataMem = dat_pipe[STAGES-1];
    end
  endgenerate
endmodule
